uidbuf_sched: RTL and testbench
===============================

Name: uidbuf_sched

Overview:
- Frame-buffer index scheduler for the FDMA multi-buffer path.
- Sequences the write-side and read-side buffer indices (fdma_wbuf / fdma_rbuf) across BUF_NUM DDR frame buffers.
- Guarantees the writer never lands on the buffer the reader holds.
- Generates the fdma_wirq / fdma_rirq pulses consumed by the buffer-IRQ register block.

Parameters:
BUF_NUM, 3, number of frame buffers; legal 2..8
IRQ_LEN, 4, irq pulse width in clocks; legal 1..15

Ports:
ui_clk  in  1  clock
ui_rst  in  1  synchronous active-high reset
enable_i  in  1  scheduler enable; low forces both sides idle
wframe_start_i  in  1  write-frame start pulse from FDMA write channel
wframe_done_i  in  1  write-frame complete pulse
rframe_start_i  in  1  read-frame start pulse from FDMA read channel
rframe_done_i  in  1  read-frame complete pulse
fdma_wbuf  out  8  buffer index currently written
fdma_wirq  out  1  write irq pulse
fdma_rbuf  out  8  buffer index currently read
fdma_rirq  out  1  read irq pulse
last_done_o  out  8  index of most recently completed write frame
done_valid_o  out  1  at least one write frame completed since reset
drop_cnt_o  out  16  frames overwritten or repeated, saturating

Behaviour:
- Reset values: fdma_wbuf=0, fdma_rbuf=BUF_NUM-1, last_done_o=0, done_valid_o=0, fdma_wirq=0, fdma_rirq=0, drop_cnt_o=0, both FSMs IDLE.
- Write FSM:
  - W_IDLE: wframe_start_i -> W_ACTIVE; fdma_wbuf unchanged.
  - W_ACTIVE: wframe_done_i -> W_IDLE with the done actions below.
  - Done actions:
    - last_done_o <= fdma_wbuf; done_valid_o <= 1.
    - n = (fdma_wbuf+1) mod BUF_NUM.
    - If the read side holds n, then n = (n+1) mod BUF_NUM.
    - If BUF_NUM==2 and the read side holds n, fdma_wbuf stays (overwrite) and drop_cnt_o increments.
  - Ignored: wframe_done_i in W_IDLE; wframe_start_i in W_ACTIVE.
- Read FSM:
  - R_IDLE: rframe_start_i -> R_ACTIVE.
    - If done_valid_o, last_done_o != fdma_rbuf and last_done_o != fdma_wbuf, then fdma_rbuf <= last_done_o (fresh frame).
    - Otherwise fdma_rbuf holds (repeat) and drop_cnt_o increments, but only if done_valid_o.
  - R_ACTIVE: rframe_done_i -> R_IDLE.
  - Ignored: rframe_done_i in R_IDLE; rframe_start_i in R_ACTIVE.
- "Read side holds n" is true when (R_ACTIVE, or R_IDLE with rframe_start_i this cycle) and n equals the post-update fdma_rbuf.
  - This rule resolves a same-cycle rframe_start_i / wframe_done_i.
  - The read decision uses pre-update last_done_o and pre-update fdma_wbuf.
- Index width: internal index is 3 bits, zero-extended to 8. Modulo is by compare-and-wrap, not division.
- IRQ outputs:
  - fdma_wirq rises on the same edge that fdma_wbuf updates (one clock after the wframe_done_i sample) and stays high IRQ_LEN clocks.
  - A new done while high restarts the count, so the pulse does not extend with a gap.
  - fdma_rirq behaves the same, triggered by the rframe_start_i acceptance edge.
  - The downstream capture therefore latches the new fdma_wbuf / fdma_rbuf values.
- Latency: event pulse sampled at edge k -> index and irq valid after edge k, visible in cycle k+1.
- enable_i low:
  - Both FSMs go to IDLE next edge.
  - Indices, last_done_o and drop_cnt_o hold; irq counters run out normally.
  - All event inputs are ignored.
- drop_cnt_o saturates at 16'hFFFF.
- ui_rst mid-frame returns everything to reset values on the next edge and drops any pending irq.
- All outputs are registered.

Test Plan:
- Reset, BUF_NUM=3, enable=1; write start/done ×3, no reads -> fdma_wbuf 0->1->2->0, last_done_o 0,1,2, fdma_wirq high 4 clocks after each done, drop_cnt_o=0.
- BUF_NUM=3, write frames 0 and 1 done (wbuf=2); read start -> rbuf=1, rirq 4 clocks. Then write done with wbuf=2 -> n=0, so wbuf=0. Next done -> n=1 held by reader, skip -> wbuf=2.
- BUF_NUM=2, reader active on rbuf=0, writer on 1 completes -> wbuf stays 1, last_done_o=1, drop_cnt_o=1.
- Read start with no new frame (last_done_o==fdma_rbuf) -> rbuf holds, drop_cnt_o increments. Before the first write done: rbuf=BUF_NUM-1, drop_cnt_o=0.
- Same-cycle rframe_start_i and wframe_done_i (BUF_NUM=3, wbuf=2, last_done=1, rbuf=0) -> rbuf=1. Write n=0 is not held, so wbuf=0. No collision: fdma_wbuf != fdma_rbuf.
- enable_i low mid-write -> FSM idle; the following wframe_done_i is ignored and wbuf is unchanged. ui_rst asserted during an irq pulse -> fdma_wirq=0 next cycle, indices 0/BUF_NUM-1.

Source files
------------

// File: rtl/uidbuf_sched.sv
// Frame-buffer index scheduler: rotates write/read buffer indices across BUF_NUM
// DDR frame buffers, keeps the writer off the reader's buffer and raises per-side irq pulses.
module uidbuf_sched #(
  parameter int BUF_NUM = 3,
  parameter int IRQ_LEN = 4
) (
  input  logic        ui_clk,
  input  logic        ui_rst,
  input  logic        enable_i,
  input  logic        wframe_start_i,
  input  logic        wframe_done_i,
  input  logic        rframe_start_i,
  input  logic        rframe_done_i,
  output logic [7:0]  fdma_wbuf,
  output logic        fdma_wirq,
  output logic [7:0]  fdma_rbuf,
  output logic        fdma_rirq,
  output logic [7:0]  last_done_o,
  output logic        done_valid_o,
  output logic [15:0] drop_cnt_o
);

  // state     | meaning
  // W_IDLE    | no write frame in flight, waiting for wframe_start_i
  // W_ACTIVE  | write frame in flight into wbuf, waiting for wframe_done_i
  // R_IDLE    | no read frame in flight, waiting for rframe_start_i
  // R_ACTIVE  | read frame in flight from rbuf, waiting for rframe_done_i
  typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;
  typedef enum logic {R_IDLE, R_ACTIVE} r_state_t;

  localparam logic [2:0] LAST_IDX = 3'(BUF_NUM - 1);
  localparam logic [3:0] IRQ_LOAD = 4'(IRQ_LEN - 1);

  w_state_t    w_state, w_next;
  r_state_t    r_state, r_next;
  logic [2:0]  wbuf, wbuf_next;
  logic [2:0]  rbuf, rbuf_next;
  logic [2:0]  last_done, last_next;
  logic        done_valid, dv_next;
  logic [15:0] drop_cnt, drop_next;
  logic [16:0] drop_sum;
  logic [3:0]  wirq_cnt, rirq_cnt;
  logic        wirq, rirq;
  logic        w_evt, r_evt, drop_w, drop_r, read_holds;
  logic [2:0]  n_first;

  function automatic logic [2:0] inc_wrap(input logic [2:0] idx);
    return (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
  endfunction

  always_comb begin
    w_next     = w_state;
    r_next     = r_state;
    wbuf_next  = wbuf;
    rbuf_next  = rbuf;
    last_next  = last_done;
    dv_next    = done_valid;
    w_evt      = 1'b0;
    r_evt      = 1'b0;
    drop_w     = 1'b0;
    drop_r     = 1'b0;
    read_holds = 1'b0;
    n_first    = inc_wrap(wbuf);

    if (!enable_i) begin
      w_next = W_IDLE;
      r_next = R_IDLE;
    end else begin
      // read side resolves first so a same-cycle write done sees the post-update rbuf
      unique case (r_state)
        R_IDLE: begin
          if (rframe_start_i) begin
            r_next     = R_ACTIVE;
            r_evt      = 1'b1;
            read_holds = 1'b1;
            if (done_valid && (last_done != rbuf) && (last_done != wbuf))
              rbuf_next = last_done;
            else if (done_valid)
              drop_r = 1'b1;
          end
        end
        R_ACTIVE: begin
          read_holds = 1'b1;
          if (rframe_done_i) r_next = R_IDLE;
        end
      endcase

      unique case (w_state)
        W_IDLE: begin
          if (wframe_start_i) w_next = W_ACTIVE;
        end
        W_ACTIVE: begin
          if (wframe_done_i) begin
            w_next    = W_IDLE;
            w_evt     = 1'b1;
            last_next = wbuf;
            dv_next   = 1'b1;
            if (read_holds && (n_first == rbuf_next)) begin
              // with two buffers the only other slot is the reader's: overwrite in place
              if (BUF_NUM == 2) drop_w = 1'b1;
              else              wbuf_next = inc_wrap(n_first);
            end else begin
              wbuf_next = n_first;
            end
          end
        end
      endcase
    end

    drop_sum  = {1'b0, drop_cnt} + 17'(drop_w) + 17'(drop_r);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge ui_clk) begin
    if (ui_rst) begin
      w_state    <= W_IDLE;
      r_state    <= R_IDLE;
      wbuf       <= 3'd0;
      rbuf       <= LAST_IDX;
      last_done  <= 3'd0;
      done_valid <= 1'b0;
      drop_cnt   <= 16'd0;
      wirq_cnt   <= 4'd0;
      rirq_cnt   <= 4'd0;
      wirq       <= 1'b0;
      rirq       <= 1'b0;
    end else begin
      w_state    <= w_next;
      r_state    <= r_next;
      wbuf       <= wbuf_next;
      rbuf       <= rbuf_next;
      last_done  <= last_next;
      done_valid <= dv_next;
      drop_cnt   <= drop_next;

      // irq down-counter: reload on a new event so the pulse restarts without a gap
      if (w_evt) begin
        wirq     <= 1'b1;
        wirq_cnt <= IRQ_LOAD;
      end else if (wirq_cnt != 4'd0) begin
        wirq_cnt <= wirq_cnt - 4'd1;
      end else begin
        wirq <= 1'b0;
      end

      if (r_evt) begin
        rirq     <= 1'b1;
        rirq_cnt <= IRQ_LOAD;
      end else if (rirq_cnt != 4'd0) begin
        rirq_cnt <= rirq_cnt - 4'd1;
      end else begin
        rirq <= 1'b0;
      end
    end
  end

  assign fdma_wbuf    = {5'd0, wbuf};
  assign fdma_rbuf    = {5'd0, rbuf};
  assign last_done_o  = {5'd0, last_done};
  assign done_valid_o = done_valid;
  assign drop_cnt_o   = drop_cnt;
  assign fdma_wirq    = wirq;
  assign fdma_rirq    = rirq;

endmodule

// File: tb/tb_uidbuf_sched.sv
// Scoreboard bench for uidbuf_sched: expected index/irq snapshots are queued at stimulus
// time and checked by monitors on each irq rising edge and on each pulse's falling edge.
module tb_uidbuf_sched;

  localparam logic [3:0] WS = 4'b1000;
  localparam logic [3:0] WD = 4'b0100;
  localparam logic [3:0] RS = 4'b0010;
  localparam logic [3:0] RD = 4'b0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en;
  logic [3:0] ev;
  logic [7:0] wbuf, rbuf, last;
  logic wirq, rirq, dv;
  logic [15:0] drop;

  logic b_rst, b_en;
  logic [3:0] b_ev;
  logic [7:0] b_wbuf, b_rbuf, b_last;
  logic b_wirq, b_rirq, b_dv;
  logic [15:0] b_drop;

  uidbuf_sched #(.BUF_NUM(3), .IRQ_LEN(4)) dut3 (
    .ui_clk(clk), .ui_rst(rst), .enable_i(en),
    .wframe_start_i(ev[3]), .wframe_done_i(ev[2]),
    .rframe_start_i(ev[1]), .rframe_done_i(ev[0]),
    .fdma_wbuf(wbuf), .fdma_wirq(wirq), .fdma_rbuf(rbuf), .fdma_rirq(rirq),
    .last_done_o(last), .done_valid_o(dv), .drop_cnt_o(drop)
  );

  uidbuf_sched #(.BUF_NUM(2), .IRQ_LEN(4)) dut2 (
    .ui_clk(clk), .ui_rst(b_rst), .enable_i(b_en),
    .wframe_start_i(b_ev[3]), .wframe_done_i(b_ev[2]),
    .rframe_start_i(b_ev[1]), .rframe_done_i(b_ev[0]),
    .fdma_wbuf(b_wbuf), .fdma_wirq(b_wirq), .fdma_rbuf(b_rbuf), .fdma_rirq(b_rirq),
    .last_done_o(b_last), .done_valid_o(b_dv), .drop_cnt_o(b_drop)
  );

  typedef struct {
    logic [7:0]  wbuf;
    logic [7:0]  rbuf;
    logic [7:0]  last;
    logic [15:0] drop;
    int          width;
  } exp_t;

  exp_t wq[$];
  exp_t rq[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse(input logic [3:0] e);
    ev = e;
    cyc();
    ev = 4'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic push_w(input int w, input int r, input int l, input int d, input int width);
    exp_t e;
    e.wbuf = 8'(w); e.rbuf = 8'(r); e.last = 8'(l); e.drop = 16'(d); e.width = width;
    wq.push_back(e);
  endtask

  task automatic push_r(input int r, input int d);
    exp_t e;
    e.wbuf = 8'd0; e.rbuf = 8'(r); e.last = 8'd0; e.drop = 16'(d); e.width = 4;
    rq.push_back(e);
  endtask

  task automatic write_frame(input int w, input int r, input int l, input int d);
    pulse(WS);
    push_w(w, r, l, d, 4);
    pulse(WD);
    gap(7);
  endtask

  // write-irq monitor
  logic wirq_q = 1'b0;
  int   w_cnt = 0;
  exp_t w_cur;
  always @(negedge clk) begin
    if (wirq && !wirq_q) begin
      if (wq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wirq_unexpected: got pulse expected none");
        w_cur.width = 0;
      end else begin
        w_cur = wq.pop_front();
        check("wirq_wbuf", 32'(wbuf), 32'(w_cur.wbuf));
        check("wirq_rbuf", 32'(rbuf), 32'(w_cur.rbuf));
        check("wirq_last", 32'(last), 32'(w_cur.last));
        check("wirq_dv", 32'(dv), 32'd1);
        check("wirq_drop", 32'(drop), 32'(w_cur.drop));
      end
      w_cnt = 1;
    end else if (wirq) begin
      w_cnt++;
    end else if (wirq_q) begin
      check("wirq_width", 32'(w_cnt), 32'(w_cur.width));
    end
    wirq_q = wirq;
  end

  // read-irq monitor
  logic rirq_q = 1'b0;
  int   r_cnt = 0;
  exp_t r_cur;
  always @(negedge clk) begin
    if (rirq && !rirq_q) begin
      if (rq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rirq_unexpected: got pulse expected none");
        r_cur.width = 0;
      end else begin
        r_cur = rq.pop_front();
        check("rirq_rbuf", 32'(rbuf), 32'(r_cur.rbuf));
        check("rirq_drop", 32'(drop), 32'(r_cur.drop));
      end
      r_cnt = 1;
    end else if (rirq) begin
      r_cnt++;
    end else if (rirq_q) begin
      check("rirq_width", 32'(r_cnt), 32'(r_cur.width));
    end
    rirq_q = rirq;
  end

  initial begin
    rst = 1'b1; en = 1'b1; ev = 4'b0;
    b_rst = 1'b1; b_en = 1'b1; b_ev = 4'b0;
    gap(2);
    rst = 1'b0; b_rst = 1'b0;
    cyc();

    check("rst_wbuf", 32'(wbuf), 32'd0);
    check("rst_rbuf", 32'(rbuf), 32'd2);
    check("rst_last", 32'(last), 32'd0);
    check("rst_dv", 32'(dv), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_irqs", 32'({wirq, rirq}), 32'd0);

    // three writes, reader idle: 0->1->2->0
    write_frame(1, 2, 0, 0);
    write_frame(2, 2, 1, 0);
    write_frame(0, 2, 2, 0);
    check("rot_wbuf", 32'(wbuf), 32'd0);

    // read before any write: holds BUF_NUM-1, no drop
    do_reset();
    push_r(2, 0); pulse(RS); gap(7); pulse(RD);
    write_frame(1, 2, 0, 0);
    write_frame(2, 2, 1, 0);
    push_r(1, 0); pulse(RS); gap(7);
    write_frame(0, 1, 2, 0);
    write_frame(2, 1, 0, 0);   // n=1 held by reader, skipped
    pulse(RD);
    push_r(0, 0); pulse(RS); gap(7); pulse(RD);
    push_r(0, 1); pulse(RS); gap(7); pulse(RD);   // repeat frame
    check("seq_dv", 32'(dv), 32'd1);
    check("seq_drop", 32'(drop), 32'd1);

    // same-cycle read start and write done
    do_reset();
    write_frame(1, 2, 0, 0);
    push_r(0, 0); pulse(RS); gap(7); pulse(RD);
    write_frame(2, 0, 1, 0);
    pulse(WS);
    push_w(0, 1, 2, 0, 4);
    push_r(1, 0);
    pulse(WD | RS);
    gap(7);
    check("same_no_collision", 32'(wbuf != rbuf), 32'd1);
    pulse(RD);

    // enable low mid-write: following done ignored
    do_reset();
    pulse(WS);
    en = 1'b0; cyc(); en = 1'b1;
    pulse(WD);
    gap(3);
    check("en_wbuf", 32'(wbuf), 32'd0);
    check("en_dv", 32'(dv), 32'd0);
    check("en_wirq", 32'(wirq), 32'd0);

    // reset during an irq pulse
    push_w(1, 2, 0, 0, 2);
    pulse(WS); pulse(WD);
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    check("rstirq_wirq", 32'(wirq), 32'd0);
    check("rstirq_wbuf", 32'(wbuf), 32'd0);
    check("rstirq_rbuf", 32'(rbuf), 32'd2);
    gap(3);

    // BUF_NUM=2 overwrite
    check("b2_rst_rbuf", 32'(b_rbuf), 32'd1);
    b_ev = WS; cyc(); b_ev = WD; cyc(); b_ev = 4'b0; cyc();
    check("b2_wbuf1", 32'(b_wbuf), 32'd1);
    b_ev = RS; cyc(); b_ev = 4'b0; cyc();
    check("b2_rbuf", 32'(b_rbuf), 32'd0);
    b_ev = WS; cyc(); b_ev = WD; cyc(); b_ev = 4'b0; cyc();
    check("b2_wbuf_hold", 32'(b_wbuf), 32'd1);
    check("b2_last", 32'(b_last), 32'd1);
    check("b2_drop", 32'(b_drop), 32'd1);

    gap(8);
    check("wq_empty", 32'(wq.size()), 32'd0);
    check("rq_empty", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
